// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder scheduler.
// Holds the Adder slice width, the scheduler state encoding and the
// helper that sizes the nibble index register.
package nibble_add_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the nibble index. A single-nibble build still needs a
   // one-bit register, so the result never drops below 1.
   function automatic int idx_w(input int nibbles);
      return (nibbles <= 1) ? 1 : $clog2(nibbles);
   endfunction

endpackage

// File: rtl/nibble_add_sched_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   valid     per-requester pending flags
//   advance   pulse on completion of a granted operation; flips priority
//   grant     index of the winning requester (only meaningful if |valid)
//   ptr       current priority pointer (0 favours requester 0)
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic       grant,
   output logic       ptr
);

   // A lone requester wins regardless of the pointer; the pointer only
   // breaks ties.
   always_comb begin
      grant = (valid == 2'b11) ? ptr : valid[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (advance) begin
         ptr <= ~ptr;
      end
   end

endmodule

// File: rtl/nibble_add_sched.sv
// Shares one external 4-bit ripple-carry Adder slice between two
// requesters. Each request adds two W-bit operands nibble-serially,
// LSB nibble first, carrying between cycles.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req0_* / req1_*    valid/ready request channels with operands a, b, cin
//   rsp_valid/ready    response handshake
//   rsp_id             requester that owns the response
//   rsp_sum, rsp_cout  (a+b+cin) mod 2^W and the final carry
//   add_a/b/cin        drive the external Adder slice
//   add_s/cout         combinational result of the external Adder slice
module nibble_add_sched
   import nibble_add_pkg::*;
#(
   parameter int NIBBLES = 4,
   localparam int W = NIBBLE_W * NIBBLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [W-1:0]        req0_a,
   input  logic [W-1:0]        req0_b,
   input  logic                req0_cin,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [W-1:0]        req1_a,
   input  logic [W-1:0]        req1_b,
   input  logic                req1_cin,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [W-1:0]        rsp_sum,
   output logic                rsp_cout,
   output logic [NIBBLE_W-1:0] add_a,
   output logic [NIBBLE_W-1:0] add_b,
   output logic                add_cin,
   input  logic [NIBBLE_W-1:0] add_s,
   input  logic                add_cout
);

   localparam int IW = idx_w(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   state_t        state, state_n;
   logic [W-1:0]  a_r, b_r, sum_r;
   logic          id_r, carry;
   logic [IW-1:0] idx;
   logic          grant, ptr, accept, advance, last;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   ({req1_valid, req0_valid}),
      .advance (advance),
      .grant   (grant),
      .ptr     (ptr)
   );

   assign last = (idx == LAST_IDX);

   always_comb begin
      state_n    = state;
      accept     = 1'b0;
      advance    = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      add_a      = '0;
      add_b      = '0;
      add_cin    = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = req0_valid & ~grant;
            req1_ready = req1_valid & grant;
            if (req0_valid | req1_valid) begin
               accept  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            add_a   = a_r[NIBBLE_W*idx +: NIBBLE_W];
            add_b   = b_r[NIBBLE_W*idx +: NIBBLE_W];
            add_cin = carry;
            if (last) state_n = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               advance = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         sum_r <= '0;
         id_r  <= 1'b0;
         carry <= 1'b0;
         idx   <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            a_r   <= grant ? req1_a : req0_a;
            b_r   <= grant ? req1_b : req0_b;
            carry <= grant ? req1_cin : req0_cin;
            id_r  <= grant;
            idx   <= '0;
         end
         if (state == RUN) begin
            sum_r[NIBBLE_W*idx +: NIBBLE_W] <= add_s;
            carry <= add_cout;
            // Park the index at 0 after the top nibble so it never points
            // past the operand.
            idx   <= last ? '0 : idx + 1'b1;
         end
      end
   end

   assign rsp_id   = id_r;
   assign rsp_sum  = sum_r;
   // The carry register holds the operand cin between accept and the first
   // RUN edge, so only expose it once the sum is complete.
   assign rsp_cout = (state == DONE) & carry;

endmodule

// File: tb/tb_nibble_add_sched.sv
module tb_nibble_add_sched;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // NIBBLES=4 instance
   logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
   logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
   logic [3:0]  add_a, add_b, add_s;
   logic        add_cin, add_cout;

   // NIBBLES=1 instance
   logic        v0_1, r0_1, c0_1, v1_1, r1_1, c1_1;
   logic [3:0]  a0_1, b0_1, a1_1, b1_1, sum_1;
   logic        rv_1, rr_1, rid_1, rc_1;
   logic [3:0]  aa_1, ab_1, as_1;
   logic        ac_1, aco_1;

   int n_run = 0;
   int n_fail = 0;
   logic [3:0] cin_seq;

   // External Adder slice models
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
   assign {aco_1, as_1}     = {1'b0, aa_1} + {1'b0, ab_1} + {4'b0, ac_1};

   nibble_add_sched #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
   );

   nibble_add_sched #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(v0_1), .req0_ready(r0_1), .req0_a(a0_1), .req0_b(b0_1), .req0_cin(c0_1),
      .req1_valid(v1_1), .req1_ready(r1_1), .req1_a(a1_1), .req1_b(b1_1), .req1_cin(c1_1),
      .rsp_valid(rv_1), .rsp_ready(rr_1), .rsp_id(rid_1), .rsp_sum(sum_1), .rsp_cout(rc_1),
      .add_a(aa_1), .add_b(ab_1), .add_cin(ac_1), .add_s(as_1), .add_cout(aco_1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One operation through the NIBBLES=4 instance. hold>0 keeps rsp_ready low
   // that many DONE cycles while the other requester asks for service.
   task automatic op(input bit who, input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input logic [15:0] esum, input logic ecout, input int hold, input string tag);
      int n;
      if (!who) begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
      else      begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
      #1;
      n = 0;
      while (!(who ? req1_ready : req0_ready) && n < 20) begin tick; n++; end
      chk({tag, " ready"}, who ? req1_ready : req0_ready, 1);
      tick;
      req0_valid = 0; req1_valid = 0;
      cin_seq = '0;
      for (int i = 0; i < N; i++) begin
         chk({tag, " run rsp_valid"}, rsp_valid, 0);
         cin_seq[i] = add_cin;
         tick;
      end
      chk({tag, " rsp_valid"}, rsp_valid, 1);
      chk({tag, " rsp_id"}, rsp_id, who);
      chk({tag, " rsp_sum"}, rsp_sum, esum);
      chk({tag, " rsp_cout"}, rsp_cout, ecout);
      if (hold > 0) begin
         if (!who) req1_valid = 1; else req0_valid = 1;
         #1;
         for (int i = 0; i < hold; i++) begin
            chk({tag, " hold rsp_valid"}, rsp_valid, 1);
            chk({tag, " hold rsp_sum"}, rsp_sum, esum);
            chk({tag, " hold rsp_cout"}, rsp_cout, ecout);
            chk({tag, " hold ready"}, {req1_ready, req0_ready}, 0);
            tick;
         end
         req0_valid = 0; req1_valid = 0;
      end
      rsp_ready = 1;
      tick;
      rsp_ready = 0;
      #1;
      chk({tag, " rsp_valid after hs"}, rsp_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int got, t, last_t;
      logic exp_id;
      rst = 1; rsp_ready = 0;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
      v0_1 = 0; a0_1 = 0; b0_1 = 0; c0_1 = 0; v1_1 = 0; a1_1 = 0; b1_1 = 0; c1_1 = 0; rr_1 = 0;
      tick; tick;
      rst = 0;
      #1;
      chk("reset rsp", {rsp_valid, rsp_id, rsp_cout}, 0);
      chk("reset sum", rsp_sum, 0);
      chk("reset add", {add_a, add_b, add_cin}, 0);
      chk("reset ready", {req1_ready, req0_ready}, 0);
      chk("reset n1", {rv_1, rid_1, rc_1, sum_1, aa_1, ab_1, ac_1, r0_1, r1_1}, 0);

      // 1: plain add, latency N
      op(0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0, "t1");
      // 2: carry ripples through every nibble
      op(1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, "t2");
      chk("t2 add_cin seq", cin_seq, 4'b1110);

      // 3: both valid continuously -> alternate ids, one op per N+2 cycles
      req0_valid = 1; req0_a = 16'h1; req0_b = 16'h1; req0_cin = 0;
      req1_valid = 1; req1_a = 16'h2; req1_b = 16'h2; req1_cin = 0;
      rsp_ready = 1;
      got = 0; t = 0; last_t = 0; exp_id = 0;
      while (got < 4 && t < 100) begin
         tick; t++;
         if (rsp_valid) begin
            chk("t3 id", rsp_id, exp_id);
            chk("t3 sum", rsp_sum, exp_id ? 16'h0004 : 16'h0002);
            if (got > 0) chk("t3 spacing", t - last_t, N + 2);
            last_t = t; got++; exp_id = ~exp_id;
            if (got == 4) begin req0_valid = 0; req1_valid = 0; end
         end
      end
      chk("t3 count", got, 4);
      tick;
      rsp_ready = 0;

      // 4: backpressure in DONE
      op(0, 16'h0003, 16'h0004, 0, 16'h0007, 0, 5, "t4");
      req1_valid = 1; req1_a = 16'h0; req1_b = 16'h0;
      #1;
      chk("t4 back to idle", req1_ready, 1);
      req1_valid = 0;
      tick;

      // 5: reset after two RUN cycles
      req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h1111; req0_cin = 1;
      tick;
      req0_valid = 0;
      tick; tick;
      rst = 1;
      tick;
      rst = 0;
      #1;
      chk("t5 rsp", {rsp_valid, rsp_id, rsp_cout}, 0);
      chk("t5 sum", rsp_sum, 0);
      chk("t5 add", {add_a, add_b, add_cin}, 0);
      chk("t5 ready", {req1_ready, req0_ready}, 0);
      got = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid) got++;
         tick;
      end
      chk("t5 no rsp", got, 0);
      op(0, 16'h000A, 16'h0005, 0, 16'h000F, 0, 0, "t5b");

      // 6: cin with full-width wrap, then single-nibble instance
      op(0, 16'h7FFF, 16'h8000, 1, 16'h0000, 1, 0, "t6");
      v0_1 = 1; a0_1 = 4'hF; b0_1 = 4'h1; c0_1 = 0;
      #1;
      chk("t6n1 ready", r0_1, 1);
      tick;
      v0_1 = 0;
      chk("t6n1 run valid", rv_1, 0);
      chk("t6n1 add_a", aa_1, 4'hF);
      tick;
      chk("t6n1 valid", rv_1, 1);
      chk("t6n1 sum", sum_1, 4'h0);
      chk("t6n1 cout", rc_1, 1);
      rr_1 = 1;
      tick;
      rr_1 = 0;
      chk("t6n1 after hs", rv_1, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
